// File: rtl/fetch_queue.sv
// In-order prefetch FIFO carrying {pc, instruction} pairs from fetch to decode.
// Latency: a push into an empty queue is visible at the head one cycle later; inReady stalls the PC when full.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     inValid,
    input  logic [AW-1:0]            pcIn,
    input  logic [DW-1:0]            instrIn,
    output logic                     inReady,
    input  logic                     flush,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [AW-1:0]            outPc,
    output logic [AW-1:0]            outPcPlus4,
    output logic [DW-1:0]            outInstr,
    output logic                     outMisalign,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
        logic          misalign;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign inReady  = (count != FULL);
    assign outValid = (count != '0);
    assign push     = inValid & inReady & ~flush;
    assign pop      = outValid & outReady & ~flush;
    assign level    = count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Redirect: everything queued belongs to the wrong path.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: pcIn, instr: instrIn, misalign: |pcIn[1:0]};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty queue presents a NOP at pc 0 so decode sees nothing stale.
    always_comb begin
        head        = mem[rd_ptr];
        outPc       = '0;
        outInstr    = '0;
        outMisalign = 1'b0;
        if (outValid) begin
            outPc       = head.pc;
            outInstr    = head.instr;
            outMisalign = head.misalign;
        end
        outPcPlus4 = outPc + AW'(4);
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model checked every cycle plus literal spot checks.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          CLK;
    logic          RST_N;
    logic          inValid;
    logic [AW-1:0] pcIn;
    logic [DW-1:0] instrIn;
    logic          inReady;
    logic          flush;
    logic          outValid;
    logic          outReady;
    logic [AW-1:0] outPc;
    logic [AW-1:0] outPcPlus4;
    logic [DW-1:0] outInstr;
    logic          outMisalign;
    logic [$clog2(DEPTH):0] level;

    int vectors;
    int miscompares;

    logic [AW+DW-1:0] mq[$];

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST_N(RST_N), .inValid(inValid), .pcIn(pcIn), .instrIn(instrIn),
        .inReady(inReady), .flush(flush), .outValid(outValid), .outReady(outReady),
        .outPc(outPc), .outPcPlus4(outPcPlus4), .outInstr(outInstr),
        .outMisalign(outMisalign), .level(level)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain FIFO of {pc, instr}.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            logic do_push, do_pop;
            do_push = inValid && (mq.size() != DEPTH);
            do_pop  = (mq.size() != 0) && outReady;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({pcIn, instrIn});
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            logic [AW-1:0] epc;
            logic [DW-1:0] ein;
            epc = (mq.size() != 0) ? mq[0][AW+DW-1:DW] : '0;
            ein = (mq.size() != 0) ? mq[0][DW-1:0] : '0;
            chk("m_outValid",    64'(outValid),    64'(mq.size() != 0));
            chk("m_outPc",       64'(outPc),       64'(epc));
            chk("m_outPcPlus4",  64'(outPcPlus4),  64'(AW'(epc + 4)));
            chk("m_outInstr",    64'(outInstr),    64'(ein));
            chk("m_outMisalign", 64'(outMisalign), 64'(epc[1:0] != 2'b00));
            chk("m_level",       64'(level),       64'(mq.size()));
            chk("m_inReady",     64'(inReady),     64'(mq.size() != DEPTH));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_one(input logic [AW-1:0] pc, input logic [DW-1:0] ins, input logic rdy);
        inValid  = 1'b1;
        pcIn     = pc;
        instrIn  = ins;
        outReady = rdy;
        step();
        inValid  = 1'b0;
    endtask

    task automatic drain();
        inValid  = 1'b0;
        flush    = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 3 * DEPTH && outValid; i++) step();
        chk("drain_empty", 64'(outValid), 64'd0);
        outReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        logic acc;
        vectors = 0; miscompares = 0;
        CLK = 1'b0; RST_N = 1'b0;
        inValid = 1'b0; pcIn = '0; instrIn = '0; flush = 1'b0; outReady = 1'b0;
        #1;
        chk("rst_outValid",   64'(outValid),   64'd0);
        chk("rst_level",      64'(level),      64'd0);
        chk("rst_inReady",    64'(inReady),    64'd1);
        chk("rst_outPcPlus4", 64'(outPcPlus4), 64'd4);
        step(); step();
        RST_N = 1'b1;
        step();

        // Fill to full, refuse a fifth push, then drain in order.
        for (int i = 0; i < 4; i++) push_one(AW'(4 * i), DW'(32'hA0 + i), 1'b0);
        chk("fill_inReady", 64'(inReady), 64'd0);
        chk("fill_level",   64'(level),   64'd4);
        push_one(32'h10, 32'hA4, 1'b0);
        chk("refuse_level", 64'(level), 64'd4);
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc",    64'(outPc),    64'(4 * i));
            chk("drain_instr", 64'(outInstr), 64'(32'hA0 + i));
            step();
        end
        chk("drained_valid", 64'(outValid), 64'd0);

        // Streaming: one word in and one out per cycle.
        for (int k = 0; k < 20; k++) begin
            push_one(32'h100 + 32'(4 * k), 32'hB000 + 32'(k), 1'b1);
            if (k == 0 || k == 19) begin
                chk("stream_level", 64'(level), 64'd1);
                chk("stream_pc",    64'(outPc), 64'(32'h100 + 4 * k));
            end
        end
        drain();

        // Flush with a simultaneous push.
        for (int i = 0; i < 3; i++) push_one(32'h20 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
        flush = 1'b1;
        push_one(32'h40, 32'hC3, 1'b1);
        flush = 1'b0;
        chk("flush_level", 64'(level),    64'd0);
        chk("flush_valid", 64'(outValid), 64'd0);
        push_one(32'h80, 32'hC4, 1'b0);
        chk("post_flush_level", 64'(level), 64'd1);
        chk("post_flush_pc",    64'(outPc), 64'h80);
        drain();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_empty_level", 64'(level), 64'd0);

        // Edge values and pointer wrap.
        push_one(32'hFFFF_FFFC, 32'hD0, 1'b0);
        chk("wrap_plus4", 64'(outPcPlus4), 64'h0);
        drain();
        push_one(32'h102, 32'hD1, 1'b0);
        chk("misalign", 64'(outMisalign), 64'd1);
        drain();
        sent = 0;
        for (int t = 0; t < 60 && sent < 3 * DEPTH; t++) begin
            acc = inReady;
            push_one(32'h300 + 32'(4 * sent), 32'hE0 + 32'(sent), (t % 3) != 0);
            if (acc) sent++;
        end
        drain();

        // Full queue with pop: push refused, one entry leaves.
        for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(4 * i), 32'hF0 + 32'(i), 1'b0);
        push_one(32'h300, 32'hF9, 1'b1);
        chk("fullpop_level", 64'(level), 64'd3);
        chk("fullpop_head",  64'(outPc), 64'h204);
        drain();

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 3; i++) push_one(32'h500 + 32'(4 * i), 32'h50 + 32'(i), 1'b0);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_outValid",   64'(outValid),   64'd0);
        chk("arst_level",      64'(level),      64'd0);
        chk("arst_inReady",    64'(inReady),    64'd1);
        chk("arst_outPcPlus4", 64'(outPcPlus4), 64'd4);
        step();
        RST_N = 1'b1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
